// File: rtl/binary_down_counter_sync.sv
// Loadable WIDTH-bit down counter with registered terminal-count borrow pulse.
// It either reloads from the last loaded value (periodic mode) or halts at zero (one-shot mode).
module binary_down_counter_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             zero,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | out of reset, no counting, enable ignored
  // RUN   | counting down on enabled edges
  // HALT  | one-shot expired, count held at 0 until next load
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      reload_reg <= '1;
      state      <= IDLE;
      borrow     <= 1'b0;
    end else if (load) begin
      // load beats a coincident terminal event: no borrow, no reload from old value
      count      <= load_value;
      reload_reg <= load_value;
      state      <= RUN;
      borrow     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (enable && (count == '0)) begin
            borrow <= 1'b1;
            if (periodic) begin
              count <= reload_reg;
            end else begin
              state <= HALT;
            end
          end else if (enable) begin
            count  <= count - ONE;
            borrow <= 1'b0;
          end else begin
            borrow <= 1'b0;
          end
        end
        HALT: begin
          count  <= '0;
          borrow <= 1'b0;
        end
        default: begin
          borrow <= 1'b0;
        end
      endcase
    end
  end

  assign count_bar = ~count;
  assign zero      = (count == '0);
  assign busy      = (state == RUN);
  assign done      = (state == HALT);

endmodule
